// File: rtl/prog_load_ctrl.sv
// UART program-load sequencer: owns CPU/programmer resets, debounces the load
// request and steers memory write ports between the programmer and the CPU.
module prog_load_ctrl #(
   parameter int unsigned DEBOUNCE     = 4,
   parameter int unsigned ARM_TIMEOUT  = 1000,
   parameter int unsigned DRAIN_CYCLES = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_pg,
   input  logic        upg_wen,
   input  logic [14:0] upg_adr,
   input  logic [31:0] upg_dat,
   input  logic        upg_done,
   input  logic        cpu_wen,
   input  logic [31:0] cpu_adr,
   input  logic [31:0] cpu_dat,
   output logic        cpu_rst,
   output logic        upg_rst,
   output logic        rom_wen,
   output logic        ram_wen,
   output logic [31:0] ram_adr,
   output logic [31:0] ram_dat,
   output logic [14:0] rom_words,
   output logic [14:0] ram_words,
   output logic        loading,
   output logic        load_err
);

   localparam int unsigned DEB_W    = $clog2(DEBOUNCE + 1);
   localparam int unsigned CYC_MAX  = (ARM_TIMEOUT > DRAIN_CYCLES) ? ARM_TIMEOUT : DRAIN_CYCLES;
   localparam int unsigned CYC_W    = $clog2(CYC_MAX + 1);
   localparam int unsigned WORD_W   = 15;
   localparam int unsigned WORD_MAX = 16384;

   typedef enum logic [1:0] {ST_RUN, ST_ARM, ST_LOAD, ST_DRAIN} state_t;

   state_t             state;
   state_t             next_state;
   logic [DEB_W-1:0]   deb_cnt;
   logic               released;
   logic [CYC_W-1:0]   cyc_cnt;
   logic               arm_c;
   logic               in_upg_c;
   logic               wr_c;
   logic               tmo_c;
   logic               drain_done_c;

   assign arm_c        = (state == ST_RUN) && start_pg && released
                         && (deb_cnt == DEB_W'(DEBOUNCE - 1));
   assign in_upg_c     = (state == ST_ARM) || (state == ST_LOAD);
   assign wr_c         = in_upg_c && upg_wen;
   assign tmo_c        = (state == ST_ARM) && (cyc_cnt == CYC_W'(ARM_TIMEOUT - 1));
   assign drain_done_c = (state == ST_DRAIN) && (cyc_cnt == CYC_W'(DRAIN_CYCLES - 1));

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_RUN;
      else       state <= next_state;
   end

   // Next-state logic; a write in ARM takes priority over done/timeout
   always_comb begin
      next_state = state;
      case (state)
         ST_RUN:   if (arm_c) next_state = ST_ARM;
         ST_ARM: begin
            if (upg_wen)       next_state = upg_done ? ST_DRAIN : ST_LOAD;
            else if (upg_done) next_state = ST_DRAIN;
            else if (tmo_c)    next_state = ST_RUN;
         end
         ST_LOAD:  if (upg_done) next_state = ST_DRAIN;
         ST_DRAIN: if (drain_done_c) next_state = ST_RUN;
         default:  next_state = ST_RUN;
      endcase
   end

   // Port steering, combinational from the registered state
   always_comb begin
      rom_wen = 1'b0;
      ram_wen = 1'b0;
      ram_adr = cpu_adr;
      ram_dat = cpu_dat;
      case (state)
         ST_RUN: ram_wen = cpu_wen;
         ST_ARM, ST_LOAD: begin
            ram_adr = {17'b0, upg_adr};
            ram_dat = upg_dat;
            ram_wen = upg_wen & upg_adr[14];
            rom_wen = upg_wen & ~upg_adr[14];
         end
         default: ;
      endcase
   end

   // Debounce: counts only in RUN; re-arm requires a release first
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         deb_cnt  <= '0;
         released <= 1'b1;
      end else begin
         if (state != ST_RUN || !start_pg)           deb_cnt <= '0;
         else if (deb_cnt != DEB_W'(DEBOUNCE - 1))   deb_cnt <= deb_cnt + DEB_W'(1);
         if (arm_c)          released <= 1'b0;
         else if (!start_pg) released <= 1'b1;
      end
   end

   // Shared cycle counter for ARM timeout and DRAIN length
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                        cyc_cnt <= '0;
      else if (state != next_state)                     cyc_cnt <= '0;
      else if (state == ST_ARM || state == ST_DRAIN)    cyc_cnt <= cyc_cnt + CYC_W'(1);
   end

   // Word counters and sticky error flag, cleared on arming
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rom_words <= '0;
         ram_words <= '0;
         load_err  <= 1'b0;
      end else if (arm_c) begin
         rom_words <= '0;
         ram_words <= '0;
         load_err  <= 1'b0;
      end else begin
         if (wr_c && !upg_adr[14] && rom_words != WORD_W'(WORD_MAX))
            rom_words <= rom_words + WORD_W'(1);
         if (wr_c && upg_adr[14] && ram_words != WORD_W'(WORD_MAX))
            ram_words <= ram_words + WORD_W'(1);
         if (state == ST_ARM && !upg_wen && (upg_done || tmo_c))
            load_err <= 1'b1;
      end
   end

   // Registered reset/status outputs track the next state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cpu_rst <= 1'b1;
         upg_rst <= 1'b1;
         loading <= 1'b0;
      end else begin
         cpu_rst <= (next_state != ST_RUN);
         upg_rst <= !(next_state == ST_ARM || next_state == ST_LOAD);
         loading <= (next_state != ST_RUN);
      end
   end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: directed table, hand sequences and random traffic
// compared against a cycle-level behavioural model.
module tb_prog_load_ctrl;

   localparam int DEBOUNCE     = 4;
   localparam int ARM_TIMEOUT  = 1000;
   localparam int DRAIN_CYCLES = 8;
   localparam int WORD_MAX     = 16384;
   localparam int P_RUN = 0, P_ARM = 1, P_LOAD = 2, P_DRAIN = 3;

   logic        clock, reset, start_pg, upg_wen, upg_done, cpu_wen;
   logic [14:0] upg_adr;
   logic [31:0] upg_dat, cpu_adr, cpu_dat;
   logic        cpu_rst, upg_rst, rom_wen, ram_wen, loading, load_err;
   logic [31:0] ram_adr, ram_dat;
   logic [14:0] rom_words, ram_words;

   int checks = 0;
   int failures = 0;

   // behavioural model state
   int   m_phase, m_hi, m_cyc, m_romw, m_ramw;
   logic m_rel, m_err, m_cpu_rst, m_upg_rst, m_loading;

   typedef struct {
      logic        sp, wen, done;
      logic [14:0] adr;
      logic        e_rom_wen, e_ram_wen;
      logic [31:0] e_ram_adr;
      logic        e_cpu_rst, e_upg_rst, e_loading;
      int          e_romw, e_ramw;
      logic        e_err;
   } vec_t;

   vec_t tbl [20];

   prog_load_ctrl #(.DEBOUNCE(DEBOUNCE), .ARM_TIMEOUT(ARM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clock(clock), .reset(reset), .start_pg(start_pg), .upg_wen(upg_wen), .upg_adr(upg_adr),
      .upg_dat(upg_dat), .upg_done(upg_done), .cpu_wen(cpu_wen), .cpu_adr(cpu_adr), .cpu_dat(cpu_dat),
      .cpu_rst(cpu_rst), .upg_rst(upg_rst), .rom_wen(rom_wen), .ram_wen(ram_wen), .ram_adr(ram_adr),
      .ram_dat(ram_dat), .rom_words(rom_words), .ram_words(ram_words), .loading(loading),
      .load_err(load_err));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic vec_t mk(input logic sp, input logic wen, input logic [14:0] adr, input logic done,
                               input logic erw, input logic emw, input logic [31:0] ea,
                               input logic ec, input logic eu, input logic el,
                               input int er, input int em, input logic ee);
      vec_t v;
      v.sp = sp; v.wen = wen; v.adr = adr; v.done = done;
      v.e_rom_wen = erw; v.e_ram_wen = emw; v.e_ram_adr = ea;
      v.e_cpu_rst = ec; v.e_upg_rst = eu; v.e_loading = el;
      v.e_romw = er; v.e_ramw = em; v.e_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = P_RUN; m_hi = 0; m_cyc = 0; m_romw = 0; m_ramw = 0;
      m_rel = 1'b1; m_err = 1'b0; m_cpu_rst = 1'b1; m_upg_rst = 1'b1; m_loading = 1'b0;
   endtask

   // One clock of the load-sequencer rules, using the inputs held before the edge
   task automatic model_step();
      int ph;
      ph = m_phase;
      if (!start_pg) m_rel = 1'b1;
      if (ph == P_RUN) begin
         m_hi = start_pg ? m_hi + 1 : 0;
         if (start_pg && m_rel && m_hi >= DEBOUNCE) begin
            m_phase = P_ARM; m_romw = 0; m_ramw = 0; m_err = 1'b0; m_rel = 1'b0; m_cyc = 0;
         end
      end else begin
         m_hi = 0;
      end
      if ((ph == P_ARM || ph == P_LOAD) && upg_wen) begin
         if (upg_adr[14]) begin if (m_ramw < WORD_MAX) m_ramw++; end
         else             begin if (m_romw < WORD_MAX) m_romw++; end
      end
      if (ph == P_ARM) begin
         if (upg_wen) m_phase = upg_done ? P_DRAIN : P_LOAD;
         else if (upg_done) begin m_err = 1'b1; m_phase = P_DRAIN; end
         else begin
            m_cyc++;
            if (m_cyc == ARM_TIMEOUT) begin m_err = 1'b1; m_phase = P_RUN; end
         end
         if (m_phase == P_DRAIN) m_cyc = 0;
      end else if (ph == P_LOAD) begin
         if (upg_done) begin m_phase = P_DRAIN; m_cyc = 0; end
      end else if (ph == P_DRAIN) begin
         m_cyc++;
         if (m_cyc == DRAIN_CYCLES) m_phase = P_RUN;
      end
      m_cpu_rst = (m_phase != P_RUN);
      m_loading = (m_phase != P_RUN);
      m_upg_rst = !(m_phase == P_ARM || m_phase == P_LOAD);
   endtask

   task automatic check_all();
      logic e_rw, e_mw;
      logic [31:0] e_a, e_d;
      e_rw = 1'b0; e_mw = 1'b0; e_a = cpu_adr; e_d = cpu_dat;
      if (m_phase == P_RUN) e_mw = cpu_wen;
      else if (m_phase == P_ARM || m_phase == P_LOAD) begin
         e_a  = {17'b0, upg_adr};
         e_d  = upg_dat;
         e_mw = upg_wen & upg_adr[14];
         e_rw = upg_wen & ~upg_adr[14];
      end
      chk("m_cpu_rst", 32'(cpu_rst), 32'(m_cpu_rst));
      chk("m_upg_rst", 32'(upg_rst), 32'(m_upg_rst));
      chk("m_loading", 32'(loading), 32'(m_loading));
      chk("m_load_err", 32'(load_err), 32'(m_err));
      chk("m_rom_words", 32'(rom_words), 32'(m_romw));
      chk("m_ram_words", 32'(ram_words), 32'(m_ramw));
      chk("m_rom_wen", 32'(rom_wen), 32'(e_rw));
      chk("m_ram_wen", 32'(ram_wen), 32'(e_mw));
      chk("m_ram_adr", ram_adr, e_a);
      chk("m_ram_dat", ram_dat, e_d);
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b0; start_pg = 1'b0; upg_wen = 1'b0; upg_adr = '0; upg_dat = 32'h0;
      upg_done = 1'b0; cpu_wen = 1'b0; cpu_adr = 32'h1234; cpu_dat = 32'hCAFE0000;
      #2 reset = 1'b1;
      #1 model_reset();
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_upg_rst", 32'(upg_rst), 32'd1);
      chk("rst_loading", 32'(loading), 32'd0);
      chk("rst_rom_wen", 32'(rom_wen), 32'd0);
      chk("rst_ram_wen", 32'(ram_wen), 32'd0);
      chk("rst_words", 32'({rom_words, ram_words}), 32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      tick();
      chk("cpu_rst_release", 32'(cpu_rst), 32'd0);

      // Directed arm + load of 3 ROM and 2 RAM words, then 8-cycle drain
      for (int i = 0; i < 3; i++) tbl[i] = mk(1, 0, 15'h0, 0, 0, 0, 32'h1234, 0, 1, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 15'h0,    0, 0, 0, 32'h1234, 1, 0, 1, 0, 0, 0);
      tbl[4]  = mk(1, 0, 15'h0,    0, 0, 0, 32'h0,    1, 0, 1, 0, 0, 0);
      tbl[5]  = mk(0, 1, 15'h0,    0, 1, 0, 32'h0,    1, 0, 1, 1, 0, 0);
      tbl[6]  = mk(0, 1, 15'h1,    0, 1, 0, 32'h1,    1, 0, 1, 2, 0, 0);
      tbl[7]  = mk(0, 0, 15'h1,    0, 0, 0, 32'h1,    1, 0, 1, 2, 0, 0);
      tbl[8]  = mk(0, 1, 15'h2,    0, 1, 0, 32'h2,    1, 0, 1, 3, 0, 0);
      tbl[9]  = mk(0, 1, 15'h4000, 0, 0, 1, 32'h4000, 1, 0, 1, 3, 1, 0);
      tbl[10] = mk(0, 1, 15'h4001, 1, 0, 1, 32'h4001, 1, 1, 1, 3, 2, 0);
      for (int i = 11; i < 18; i++) tbl[i] = mk(0, 1, 15'h4005, 1, 0, 0, 32'h1234, 1, 1, 1, 3, 2, 0);
      tbl[18] = mk(0, 1, 15'h4005, 1, 0, 0, 32'h1234, 0, 1, 0, 3, 2, 0);
      tbl[19] = mk(0, 1, 15'h4005, 1, 0, 0, 32'h1234, 0, 1, 0, 3, 2, 0);
      for (int i = 0; i < 20; i++) begin
         start_pg = tbl[i].sp; upg_wen = tbl[i].wen; upg_adr = tbl[i].adr; upg_done = tbl[i].done;
         upg_dat = 32'hA5000000 | 32'(i);
         #1;
         chk($sformatf("tbl%0d_rom_wen", i), 32'(rom_wen), 32'(tbl[i].e_rom_wen));
         chk($sformatf("tbl%0d_ram_wen", i), 32'(ram_wen), 32'(tbl[i].e_ram_wen));
         chk($sformatf("tbl%0d_ram_adr", i), ram_adr, tbl[i].e_ram_adr);
         tick();
         chk($sformatf("tbl%0d_cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].e_cpu_rst));
         chk($sformatf("tbl%0d_upg_rst", i), 32'(upg_rst), 32'(tbl[i].e_upg_rst));
         chk($sformatf("tbl%0d_loading", i), 32'(loading), 32'(tbl[i].e_loading));
         chk($sformatf("tbl%0d_rom_words", i), 32'(rom_words), 32'(tbl[i].e_romw));
         chk($sformatf("tbl%0d_ram_words", i), 32'(ram_words), 32'(tbl[i].e_ramw));
         chk($sformatf("tbl%0d_load_err", i), 32'(load_err), 32'(tbl[i].e_err));
      end

      // RUN: CPU owns the RAM port, programmer strobes ignored
      cpu_wen = 1'b1; cpu_adr = 32'h10; cpu_dat = 32'hDEADBEEF;
      upg_wen = 1'b1; upg_adr = 15'h0003; upg_done = 1'b0;
      #1;
      chk("run_ram_wen", 32'(ram_wen), 32'd1);
      chk("run_ram_adr", ram_adr, 32'h10);
      chk("run_ram_dat", ram_dat, 32'hDEADBEEF);
      chk("run_rom_wen", 32'(rom_wen), 32'd0);
      tick();
      chk("run_words", 32'({rom_words, ram_words}), 32'({15'd3, 15'd2}));

      // Timeout abort with start_pg held high throughout; no re-arm until release
      upg_wen = 1'b0; start_pg = 1'b1;
      ticks(DEBOUNCE);
      chk("tmo_armed", 32'(loading), 32'd1);
      ticks(ARM_TIMEOUT - 1);
      chk("tmo_still_arm", 32'(loading), 32'd1);
      tick();
      chk("tmo_loading", 32'(loading), 32'd0);
      chk("tmo_load_err", 32'(load_err), 32'd1);
      chk("tmo_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("tmo_upg_rst", 32'(upg_rst), 32'd1);
      ticks(10);
      chk("held_no_rearm", 32'(loading), 32'd0);
      start_pg = 1'b0;
      tick();
      start_pg = 1'b1;
      ticks(DEBOUNCE - 1);
      chk("rearm_early", 32'(loading), 32'd0);
      tick();
      chk("rearm_loading", 32'(loading), 32'd1);
      chk("rearm_err_clr", 32'(load_err), 32'd0);

      // Empty load: done with no write goes through DRAIN with error
      start_pg = 1'b0; upg_done = 1'b1;
      tick();
      chk("empty_err", 32'(load_err), 32'd1);
      chk("empty_upg_rst", 32'(upg_rst), 32'd1);
      ticks(DRAIN_CYCLES - 1);
      chk("empty_drain_cpu_rst", 32'(cpu_rst), 32'd1);
      tick();
      chk("empty_run_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("empty_words", 32'({rom_words, ram_words}), 32'd0);
      ticks(3);
      chk("done_held_run", 32'(loading), 32'd0);

      // Counter saturation, then asynchronous reset in the middle of LOAD
      upg_done = 1'b0; start_pg = 1'b1;
      ticks(DEBOUNCE);
      start_pg = 1'b0; upg_wen = 1'b1; upg_adr = 15'h0000;
      ticks(WORD_MAX + 6);
      chk("sat_rom_words", 32'(rom_words), 32'(WORD_MAX));
      upg_adr = 15'h4000;
      ticks(5);
      chk("load_ram_words", 32'(ram_words), 32'd5);
      cpu_wen = 1'b0;
      reset = 1'b1;
      #1 model_reset();
      chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("mid_rst_upg_rst", 32'(upg_rst), 32'd1);
      chk("mid_rst_loading", 32'(loading), 32'd0);
      chk("mid_rst_words", 32'({rom_words, ram_words}), 32'd0);
      chk("mid_rst_ram_wen", 32'(ram_wen), 32'd0);
      #1 reset = 1'b0;
      tick();
      chk("mid_rst_release", 32'(cpu_rst), 32'd0);

      // Random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         start_pg = ($urandom_range(0, 9) < 6);
         upg_wen  = 1'($urandom_range(0, 1));
         upg_adr  = 15'($urandom);
         upg_dat  = $urandom;
         upg_done = ($urandom_range(0, 39) == 0);
         cpu_wen  = 1'($urandom_range(0, 1));
         cpu_adr  = $urandom;
         cpu_dat  = $urandom;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
